// File: rtl/dm_banked_if.sv
// Request/response bundle for the banked data memory in the MEM stage.
`timescale 1ns/1ps

interface dm_banked_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_sign;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [31:0]       req_pc;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  modport master (
    output req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );

  modport slave (
    input  req_valid, req_we, req_size, req_sign, req_addr, req_wdata, req_pc,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy
  );
endinterface

// File: rtl/dm_banked.sv
// Byte-addressed, lane-enabled data RAM with registered responses, size/sign-aware
// load extraction, alignment/range error reporting and an optional post-reset clear sweep.
`timescale 1ns/1ps

module dm_banked #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned DEPTH          = 4096,
  parameter int unsigned ADDR_W         = 32,
  parameter bit          CLEAR_ON_RESET = 1'b1
) (
  input logic        clk,
  input logic        reset,
  dm_banked_if.slave bus
);

  localparam int unsigned BYTES = DATA_W / 8;
  localparam int unsigned OFF_W = $clog2(BYTES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam longint unsigned MEM_BYTES = 64'(DEPTH) * 64'(BYTES);

  typedef enum logic {S_INIT, S_RUN} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  clr_q, clr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              mem_we;
  logic [IDX_W-1:0]  mem_idx;
  logic [DATA_W-1:0] mem_wdata;

  logic [IDX_W-1:0]  idx;
  logic [OFF_W-1:0]  off;
  logic [3:0]        nbytes;
  logic [6:0]        nbits;
  logic              misalign, oversize, out_range, err_c, sbit;
  logic [DATA_W-1:0] word, shifted, msb_mask, lo_mask, bmask, wrep, merged, ext;

  // Request decode: lane masks, store merge and load extraction all hang off the address.
  always_comb begin
    idx       = bus.req_addr[IDX_W+OFF_W-1:OFF_W];
    off       = bus.req_addr[OFF_W-1:0];
    oversize  = (bus.req_size == 2'd3) && (DATA_W == 32);
    out_range = 64'(bus.req_addr) >= MEM_BYTES;
    case (bus.req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = bus.req_addr[0];
      2'd2:    misalign = |bus.req_addr[1:0];
      default: misalign = |bus.req_addr[2:0];
    endcase
    err_c    = misalign | oversize | out_range;
    nbytes   = oversize ? 4'(BYTES) : (4'd1 << bus.req_size);
    nbits    = {nbytes, 3'b000};
    msb_mask = DATA_W'(1) << (nbits - 7'd1);
    // Wraps to all-ones when the access spans the full word.
    lo_mask  = (msb_mask << 1) - DATA_W'(1);
    word     = mem[idx];
    shifted  = word >> {off, 3'b000};
    sbit     = bus.req_sign & (|(shifted & msb_mask));
    ext      = (shifted & lo_mask) | ({DATA_W{sbit}} & ~lo_mask);
    // Aligned accesses make a plain shift equal to replicating the low bytes.
    bmask    = lo_mask << {off, 3'b000};
    wrep     = bus.req_wdata << {off, 3'b000};
    merged   = (word & ~bmask) | (wrep & bmask);
  end

  // Next-state, memory write port and response staging.
  always_comb begin
    state_d     = state_q;
    clr_d       = clr_q;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    rsp_rdata_d = '0;
    mem_we      = 1'b0;
    mem_idx     = idx;
    mem_wdata   = merged;
    case (state_q)
      S_INIT: begin
        mem_we    = 1'b1;
        mem_idx   = clr_q;
        mem_wdata = '0;
        clr_d     = clr_q + IDX_W'(1);
        if (clr_q == IDX_W'(DEPTH - 1)) begin
          state_d = S_RUN;
          clr_d   = '0;
        end
      end
      default: begin
        if (bus.req_valid) begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = err_c;
          mem_we      = ~err_c & bus.req_we;
          if (!err_c && !bus.req_we) rsp_rdata_d = ext;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= CLEAR_ON_RESET ? S_INIT : S_RUN;
      clr_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      clr_q       <= clr_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // Storage array carries no reset; writes are suppressed while reset is held.
  always_ff @(posedge clk) begin
    if (mem_we && reset) mem[mem_idx] <= mem_wdata;
  end

  assign bus.busy      = (state_q == S_INIT);
  assign bus.req_ready = (state_q == S_RUN);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;

  logic unused_pc;
  assign unused_pc = ^bus.req_pc;

endmodule

// File: tb/tb_dm_banked.sv
// Scoreboard bench for dm_banked: 32- and 64-bit instances against a byte-array reference model.
`timescale 1ns/1ps

module tb_dm_banked;

  localparam int unsigned DEPTH = 16;

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;

  exp_t q32[$];
  exp_t q64[$];
  exp_t e32, e64;

  logic [7:0] m32 [DEPTH*4];
  logic [7:0] m64 [DEPTH*8];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dm_banked_if #(.DATA_W(32), .ADDR_W(32)) b32();
  dm_banked_if #(.DATA_W(64), .ADDR_W(32)) b64();

  dm_banked #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)) dut32 (
    .clk(clk), .reset(reset), .bus(b32.slave));
  dm_banked #(.DATA_W(64), .DEPTH(DEPTH), .ADDR_W(32), .CLEAR_ON_RESET(1'b1)) dut64 (
    .clk(clk), .reset(reset), .bus(b64.slave));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Byte-level reference: memory is a flat byte array, little-endian.
  function automatic exp_t model(input bit wide, input bit we, input logic [1:0] size,
                                 input bit sign, input logic [31:0] addr, input logic [63:0] wdata);
    exp_t        r;
    int unsigned nb;
    longint unsigned lim;
    logic [63:0] v;
    nb  = 1 << size;
    lim = longint'(DEPTH) * (wide ? 8 : 4);
    v   = '0;
    r.cyc  = 0;
    r.data = '0;
    r.err  = (size == 2'd3 && !wide) || (addr % nb != 0) || (longint'(addr) >= lim);
    if (!r.err) begin
      for (int k = 0; k < int'(nb); k++) begin
        if (we) begin
          if (wide) m64[addr + k] = wdata[8*k +: 8];
          else      m32[addr + k] = wdata[8*k +: 8];
        end else begin
          v[8*k +: 8] = wide ? m64[addr + k] : m32[addr + k];
        end
      end
      if (!we) begin
        if (sign && v[8*nb - 1])
          for (int k = 8*int'(nb); k < 64; k++) v[k] = 1'b1;
        r.data = wide ? v : {32'h0, v[31:0]};
      end
    end
    return r;
  endfunction

  task automatic req(input bit wide, input bit we, input logic [1:0] size, input bit sign,
                     input logic [31:0] addr, input logic [63:0] wdata);
    exp_t e;
    @(posedge clk); #1;
    b32.req_valid = 1'b0;
    b64.req_valid = 1'b0;
    if (wide) begin
      check("ready64", 64'(b64.req_ready), 64'd1);
      b64.req_we = we; b64.req_size = size; b64.req_sign = sign;
      b64.req_addr = addr; b64.req_wdata = wdata; b64.req_pc = 32'(cyc * 4);
      b64.req_valid = 1'b1;
    end else begin
      check("ready32", 64'(b32.req_ready), 64'd1);
      b32.req_we = we; b32.req_size = size; b32.req_sign = sign;
      b32.req_addr = addr; b32.req_wdata = wdata[31:0]; b32.req_pc = 32'(cyc * 4);
      b32.req_valid = 1'b1;
    end
    e = model(wide, we, size, sign, addr, wdata);
    e.cyc = cyc;
    if (wide) q64.push_back(e);
    else      q32.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk); #1;
    b32.req_valid = 1'b0;
    b64.req_valid = 1'b0;
  endtask

  task automatic sweep_len(input int limit, output int n32, output int n64, output int rdy_bad);
    n32 = 0; n64 = 0; rdy_bad = 0;
    for (int c = 0; c < limit; c++) begin
      if (b32.busy) n32++;
      if (b64.busy) n64++;
      if ((b32.busy && b32.req_ready) || (b64.busy && b64.req_ready)) rdy_bad++;
      @(negedge clk);
    end
  endtask

  // Response monitor: every response pops the oldest expectation of its instance.
  always @(negedge clk) begin
    if (reset && b32.rsp_valid) begin
      if (q32.size() == 0) check("rsp32_unexpected", 64'(b32.rsp_valid), 64'd0);
      else begin
        e32 = q32.pop_front();
        check("rdata32", 64'(b32.rsp_rdata), e32.data);
        check("err32", 64'(b32.rsp_err), 64'(e32.err));
        check("latency32", 64'(cyc), 64'(e32.cyc + 1));
      end
    end
    if (reset && b64.rsp_valid) begin
      if (q64.size() == 0) check("rsp64_unexpected", 64'(b64.rsp_valid), 64'd0);
      else begin
        e64 = q64.pop_front();
        check("rdata64", b64.rsp_rdata, e64.data);
        check("err64", 64'(b64.rsp_err), 64'(e64.err));
        check("latency64", 64'(cyc), 64'(e64.cyc + 1));
      end
    end
  end

  initial begin
    int n32, n64, bad;
    bit wide;
    logic [1:0] size;
    logic [31:0] addr;
    int unsigned lim;

    for (int i = 0; i < DEPTH*4; i++) m32[i] = 8'h00;
    for (int i = 0; i < DEPTH*8; i++) m64[i] = 8'h00;
    reset = 1'b0;
    b32.req_valid = 0; b32.req_we = 0; b32.req_size = 0; b32.req_sign = 0;
    b32.req_addr = 0; b32.req_wdata = 0; b32.req_pc = 0;
    b64.req_valid = 0; b64.req_we = 0; b64.req_size = 0; b64.req_sign = 0;
    b64.req_addr = 0; b64.req_wdata = 0; b64.req_pc = 0;

    repeat (3) @(negedge clk);
    check("rst_rsp_valid32", 64'(b32.rsp_valid), 64'd0);
    check("rst_rsp_rdata32", 64'(b32.rsp_rdata), 64'd0);
    check("rst_rsp_err32", 64'(b32.rsp_err), 64'd0);
    check("rst_busy32", 64'(b32.busy), 64'd1);
    check("rst_ready32", 64'(b32.req_ready), 64'd0);
    check("rst_rsp_valid64", 64'(b64.rsp_valid), 64'd0);
    check("rst_busy64", 64'(b64.busy), 64'd1);

    // Full sweep after reset release.
    reset = 1'b1;
    sweep_len(20, n32, n64, bad);
    check("sweep_len32", 64'(n32), 64'(DEPTH));
    check("sweep_len64", 64'(n64), 64'(DEPTH));
    check("sweep_ready_low", 64'(bad), 64'd0);

    // Reset at sweep cycle 5 restarts the sweep from zero.
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    sweep_len(20, n32, n64, bad);
    check("resweep_len32", 64'(n32), 64'(DEPTH));
    check("resweep_len64", 64'(n64), 64'(DEPTH));
    check("resweep_ready_low", 64'(bad), 64'd0);
    check("run_ready32", 64'(b32.req_ready), 64'd1);
    check("run_busy64", 64'(b64.busy), 64'd0);

    // 32-bit directed cases.
    req(0, 0, 2'd2, 0, 32'h3C, 0);
    req(0, 1, 2'd2, 0, 32'h10, 64'hDEADBEEF);
    req(0, 0, 2'd2, 0, 32'h10, 0);
    req(0, 0, 2'd2, 0, 32'h10, 0);
    req(0, 1, 2'd0, 0, 32'h12, 64'hA5);
    req(0, 0, 2'd2, 0, 32'h10, 0);
    req(0, 0, 2'd0, 1, 32'h12, 0);
    req(0, 0, 2'd0, 0, 32'h12, 0);
    req(0, 1, 2'd1, 0, 32'h10, 64'h1234);
    req(0, 0, 2'd1, 1, 32'h10, 0);
    req(0, 1, 2'd2, 0, 32'h11, 64'h55555555);
    req(0, 0, 2'd2, 0, 32'h10, 0);
    req(0, 0, 2'd1, 0, 32'h13, 0);
    req(0, 0, 2'd2, 0, 32'(DEPTH*4), 0);
    req(0, 1, 2'd3, 0, 32'h8, 64'hFFFF);
    idle();

    // 64-bit directed cases.
    req(1, 1, 2'd3, 0, 32'h8, 64'h0123456789ABCDEF);
    req(1, 0, 2'd2, 1, 32'hC, 0);
    req(1, 0, 2'd0, 1, 32'hB, 0);
    req(1, 0, 2'd3, 0, 32'h4, 0);
    req(1, 0, 2'd3, 0, 32'(DEPTH*8), 0);
    req(1, 0, 2'd3, 0, 32'h8, 0);
    idle();

    // Randomised mix across both instances, mostly aligned, some past the end.
    for (int n = 0; n < 400; n++) begin
      wide = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      lim  = DEPTH * (wide ? 8 : 4);
      addr = 32'($urandom_range(0, lim + 7));
      if ($urandom_range(0, 3) != 0) addr = addr & ~(32'(1 << size) - 32'd1);
      req(wide, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr,
          {32'($urandom), 32'($urandom)});
      if ($urandom_range(0, 7) == 0) idle();
    end
    idle();
    repeat (4) @(negedge clk);
    check("pending32", 64'(q32.size()), 64'd0);
    check("pending64", 64'(q64.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1);
  end

endmodule

// File: doc/dm_banked.md
Name: dm_banked

Overview:
- Parametrised successor to the single-cycle data memory: byte-addressed, byte-lane-enabled data RAM with a registered read port and a valid/ready request interface.
- Adds size/sign-aware load extraction, misalignment and out-of-range error reporting, and a post-reset clear sweep.
- Sits in the MEM stage between the ALU address path and the writeback mux.

Parameters:
- DATA_W, 32, word width in bits. Legal values are 32 or 64. BYTES = DATA_W/8; OFF_W = log2(BYTES).
- DEPTH, 4096, number of words. Must be a power of two. IDX_W = log2(DEPTH).
- ADDR_W, 32, request byte-address width.
- CLEAR_ON_RESET, 1. When 1, all words are zeroed after reset release. When 0, no sweep is run.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready at a clk edge.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 0 = byte, 1 = half, 2 = word32, 3 = dword (only legal when DATA_W = 64).
- req_sign  in  1  loads only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (LSB lanes).
- req_pc  in  32  PC of the issuing instruction; used by the store log only.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  DATA_W  load result, extended to DATA_W; 0 for stores and errors.
- rsp_err  out  1  qualifies rsp_valid: access was misaligned, oversize, or out of range.
- busy  out  1  high while the clear sweep is in progress.

Behaviour:
- States: INIT, RUN.
  - reset asserted (low): state = INIT if CLEAR_ON_RESET else RUN; clr_cnt = 0; rsp_valid = 0; rsp_rdata = 0; rsp_err = 0.
  - busy and req_ready are combinational from state.
- INIT:
  - Each cycle writes 0 to word clr_cnt, then increments clr_cnt.
  - When clr_cnt == DEPTH-1 the write still occurs and the next state is RUN.
  - Sweep takes exactly DEPTH cycles.
  - busy = 1, req_ready = 0.
  - Reset asserted mid-sweep restarts the sweep at 0.
- RUN:
  - busy = 0, req_ready = 1; one request accepted per cycle, no bubbles.
  - Word index = req_addr[IDX_W+OFF_W-1:OFF_W]; lane offset = req_addr[OFF_W-1:0].
- Error check, evaluated at accept:
  - Misaligned when the address is not a multiple of the access size: half needs addr[0] == 0, word32 needs addr[1:0] == 0, dword needs addr[2:0] == 0.
  - size = 3 with DATA_W = 32 is an error.
  - req_addr >= DEPTH*BYTES is an error.
  - An erroring access never writes memory.
- Store:
  - Byte enables cover the lanes selected by offset and size.
  - The low bytes of req_wdata are replicated into the selected lanes; unselected lanes keep their old contents.
  - Memory is updated at the accepting edge.
  - Simulation-only log line: "%d@%h: *%h <= %h" giving time, req_pc, word-aligned address, and the merged word.
- Load:
  - Memory is read at the accepting edge.
  - The selected lanes are shifted to the LSB, then extended per req_sign.
- Response (loads and stores):
  - rsp_valid is high exactly 1 cycle after accept.
  - rsp_err is valid while rsp_valid is high.
  - No backpressure on the response.
- Hazards and ordering:
  - A store accepted in cycle N followed by a load to the same word in cycle N+1 returns the new data. No forwarding logic is needed.
  - Responses are returned in request order.
- Reset arriving with a response pending: the response is dropped (rsp_valid = 0 immediately).
- Memory contents are not guaranteed across reset when CLEAR_ON_RESET = 0.

Test Plan:
- Sweep timing. Release reset with DEPTH = 16, CLEAR_ON_RESET = 1 → busy high for exactly 16 cycles, req_ready low throughout; a load of 0x3C afterwards returns 0. Assert reset at sweep cycle 5 → sweep restarts and lasts a full 16 cycles.
- Word store/load. Store word 0xDEADBEEF at 0x10, then load word 0x10 the next cycle → rsp_rdata = 0xDEADBEEF, rsp_err = 0, one-cycle latency, loads back-to-back with no gap.
- Byte/half merge. With word 0x10 = 0xDEADBEEF:
  - Store byte 0xA5 at 0x12 → word reads 0xDEA5BEEF.
  - Load byte signed at 0x12 → 0xFFFFFFA5.
  - Load byte unsigned → 0x000000A5.
  - Store half 0x1234 at 0x10, then load half signed at 0x10 → 0x00001234.
- Misalignment and range.
  - Store word at 0x11 → rsp_err = 1; the word at 0x10 is unchanged.
  - Load half at 0x13 → rsp_err = 1, rsp_rdata = 0.
  - Access at DEPTH*4 → rsp_err = 1.
- 64-bit mode. With DATA_W = 64:
  - Store dword 0x0123456789ABCDEF at 0x8, then load word signed at 0xC → 0x0000000001234567.
  - Load byte signed at 0xB → 0xFFFFFFFFFFFFFF89.
  - Dword access at 0x4 → rsp_err = 1.
